dls_fault_monitor: RTL and testbench

- Downstream consumer of the dual-lockstep VGA comparator's DLS_ERROR output.
- Filters glitches by requiring N consecutive mismatch cycles before a fault is confirmed.
- Latches confirmed faults (sticky), counts confirmed fault events, and raises an interrupt plus a safe-state flag.
- Exposes status, count, control and clear through a zero-wait AHB-Lite slave register file.

---
 rtl/dls_fault_monitor.sv | 218 +++++++++++++++++++++
 tb/tb_dls_fault_monitor.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dls_fault_monitor.sv
// Glitch-filtered monitor for the lockstep comparator error with a sticky latch, event counter and AHB-Lite registers.
// Define DLS_FAULT_TIMESTAMP_EN to add a free-running cycle counter and the FIRST_TS register at 0x10.
module dls_fault_monitor #(
    parameter int FILTER_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        DLS_ERROR,
    input  logic        HSEL,
    input  logic [4:0]  HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        FAULT_IRQ,
    output logic        FAULT_LATCHED
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        FAULT   = 2'd2
    } state_t;

    localparam logic [3:0]       FILT_TARGET = 4'(FILTER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    localparam logic [2:0] A_STATUS = 3'd0;
    localparam logic [2:0] A_COUNT  = 3'd1;
    localparam logic [2:0] A_CTRL   = 3'd2;
    localparam logic [2:0] A_CLEAR  = 3'd3;
    localparam logic [2:0] A_TS     = 3'd4;

    state_t           state_q, state_d;
    logic [3:0]       filt_q, filt_d;
    logic             confirm;
    logic             latch_q, latch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             irq_en_q, irq_en_d;
    logic             mon_en_q, mon_en_d;

    logic             dvalid_q;
    logic             dwrite_q;
    logic [2:0]       daddr_q;
    logic             wr_en;
    logic             ctrl_wr;
    logic             clr_latch;
    logic             clr_cnt;
    logic [31:0]      ts_rd;
    logic [31:0]      rdata;
    logic             unused_bits;

    assign unused_bits = ^{HADDR[1:0], HTRANS[0], HWDATA[31:2]};

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= IDLE;
            filt_q  <= '0;
        end else begin
            state_q <= state_d;
            filt_q  <= filt_d;
        end
    end

    // Disabling the monitor parks the filter so re-enabling always starts a fresh count.
    always_comb begin
        state_d = state_q;
        filt_d  = filt_q;
        confirm = 1'b0;
        if (!mon_en_q) begin
            state_d = IDLE;
            filt_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (DLS_ERROR) begin
                        filt_d = 4'd1;
                        if (FILTER_CYCLES == 1) begin
                            state_d = FAULT;
                            confirm = 1'b1;
                        end else begin
                            state_d = PENDING;
                        end
                    end
                end
                PENDING: begin
                    if (DLS_ERROR) begin
                        filt_d = filt_q + 4'd1;
                        if (filt_q + 4'd1 == FILT_TARGET) begin
                            state_d = FAULT;
                            confirm = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                        filt_d  = '0;
                    end
                end
                FAULT: begin
                    if (!DLS_ERROR) begin
                        state_d = IDLE;
                        filt_d  = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    filt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dvalid_q <= 1'b0;
            dwrite_q <= 1'b0;
            daddr_q  <= '0;
        end else if (HREADY) begin
            dvalid_q <= HSEL & HTRANS[1];
            dwrite_q <= HWRITE;
            daddr_q  <= HADDR[4:2];
        end
    end

    assign wr_en     = dvalid_q & dwrite_q & HREADY;
    assign ctrl_wr   = wr_en & (daddr_q == A_CTRL);
    assign clr_latch = wr_en & (daddr_q == A_CLEAR) & HWDATA[0];
    assign clr_cnt   = wr_en & (daddr_q == A_CLEAR) & HWDATA[1];

    // Clears are applied first so a coincident confirm overrides them.
    always_comb begin
        latch_d  = latch_q;
        cnt_d    = cnt_q;
        sat_d    = sat_q;
        irq_en_d = irq_en_q;
        mon_en_d = mon_en_q;
        if (clr_latch) begin
            latch_d = 1'b0;
        end
        if (clr_cnt) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end
        if (confirm) begin
            latch_d = 1'b1;
            if (cnt_d == CNT_MAX) begin
                sat_d = 1'b1;
            end else begin
                cnt_d = cnt_d + CNT_ONE;
            end
        end
        if (ctrl_wr) begin
            irq_en_d = HWDATA[0];
            mon_en_d = HWDATA[1];
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            latch_q  <= 1'b0;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            irq_en_q <= 1'b0;
            mon_en_q <= 1'b1;
        end else begin
            latch_q  <= latch_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
            irq_en_q <= irq_en_d;
            mon_en_q <= mon_en_d;
        end
    end

`ifdef DLS_FAULT_TIMESTAMP_EN
    logic [31:0] ts_q;
    logic [31:0] first_ts_q;

    // Capture is armed whenever the latch is empty or being cleared in the same cycle.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ts_q       <= '0;
            first_ts_q <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
            if (confirm && (!latch_q || clr_latch)) begin
                first_ts_q <= ts_q;
            end
        end
    end

    assign ts_rd = first_ts_q;
`else
    assign ts_rd = '0;
`endif

    always_comb begin
        rdata = '0;
        if (dvalid_q && !dwrite_q) begin
            unique case (daddr_q)
                A_STATUS: rdata = {28'd0, state_q == PENDING, sat_q, state_q == FAULT, latch_q};
                A_COUNT:  rdata = 32'(cnt_q);
                A_CTRL:   rdata = {30'd0, mon_en_q, irq_en_q};
                A_TS:     rdata = ts_rd;
                default:  rdata = '0;
            endcase
        end
    end

    assign HRDATA        = rdata;
    assign HREADYOUT     = 1'b1;
    assign FAULT_LATCHED = latch_q;
    assign FAULT_IRQ     = latch_q & irq_en_q;

endmodule

// File: tb/tb_dls_fault_monitor.sv
// Scoreboard bench: two monitors (16-bit and 2-bit counters) share one bus and one error input.
module tb_dls_fault_monitor;

    logic        clock = 1'b0;
    logic        reset;
    logic        dlsError;
    logic        hSel;
    logic [4:0]  hAddr;
    logic [1:0]  hTrans;
    logic        hWrite;
    logic        hReady;
    logic [31:0] hWdata;
    logic [31:0] rdataA, rdataB;
    logic        readyA, readyB;
    logic        irqA, irqB;
    logic        latA, latB;

    int total = 0;
    int bad   = 0;

    logic [31:0] expQA[$];
    logic [31:0] expQB[$];
    string       tagQ[$];

    int cntA, cntB;
    bit satA, satB;

    always #5 clock = ~clock;

    dls_fault_monitor #(.FILTER_CYCLES(2), .CNT_W(16)) dutA (
        .HCLK(clock), .HRESET(reset), .DLS_ERROR(dlsError),
        .HSEL(hSel), .HADDR(hAddr), .HTRANS(hTrans), .HWRITE(hWrite),
        .HREADY(hReady), .HWDATA(hWdata), .HRDATA(rdataA), .HREADYOUT(readyA),
        .FAULT_IRQ(irqA), .FAULT_LATCHED(latA)
    );

    dls_fault_monitor #(.FILTER_CYCLES(2), .CNT_W(2)) dutB (
        .HCLK(clock), .HRESET(reset), .DLS_ERROR(dlsError),
        .HSEL(hSel), .HADDR(hAddr), .HTRANS(hTrans), .HWRITE(hWrite),
        .HREADY(hReady), .HWDATA(hWdata), .HRDATA(rdataB), .HREADYOUT(readyB),
        .FAULT_IRQ(irqB), .FAULT_LATCHED(latB)
    );

`ifdef DLS_FAULT_TIMESTAMP_EN
    logic [31:0] cyc;
    logic [31:0] tsExp;
    always @(posedge clock) begin
        if (reset) cyc <= '0;
        else       cyc <= cyc + 32'd1;
    end
`endif

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] b2w(input logic b);
        return {31'd0, b};
    endfunction

    function automatic logic [31:0] st(input bit pend, input bit sat, input bit flt, input bit lat);
        return {28'd0, pend, sat, flt, lat};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic err, input int n);
        dlsError = err;
        repeat (n) tick();
    endtask

    task automatic modelConfirm();
        if (cntA == 65535) satA = 1'b1; else cntA++;
        if (cntB == 3)     satB = 1'b1; else cntB++;
    endtask

    task automatic modelClearCount();
        cntA = 0; cntB = 0; satA = 1'b0; satB = 1'b0;
    endtask

    task automatic popCompare();
        string       t;
        logic [31:0] ea, eb;
        t  = tagQ.pop_front();
        ea = expQA.pop_front();
        eb = expQB.pop_front();
        checkOutput({t, "_w16"}, rdataA, ea);
        checkOutput({t, "_w2"}, rdataB, eb);
    endtask

    task automatic busRead(input logic [4:0] addr, input logic [31:0] expA, input logic [31:0] expB, input string tag);
        hSel = 1'b1; hTrans = 2'b10; hWrite = 1'b0; hAddr = addr;
        expQA.push_back(expA);
        expQB.push_back(expB);
        tagQ.push_back(tag);
        tick();
        hSel = 1'b0; hTrans = 2'b00;
        popCompare();
    endtask

    task automatic busWrite(input logic [4:0] addr, input logic [31:0] data);
        hSel = 1'b1; hTrans = 2'b10; hWrite = 1'b1; hAddr = addr;
        tick();
        hSel = 1'b0; hTrans = 2'b00; hWrite = 1'b0; hWdata = data;
        tick();
    endtask

    task automatic burst();
        applyStimulus(1'b1, 4);
        applyStimulus(1'b0, 2);
        modelConfirm();
    endtask

    task automatic checkLatch(input string tag, input logic exp);
        checkOutput({tag, "_latA"}, b2w(latA), b2w(exp));
        checkOutput({tag, "_latB"}, b2w(latB), b2w(exp));
    endtask

    task automatic checkIrq(input string tag, input logic exp);
        checkOutput({tag, "_irqA"}, b2w(irqA), b2w(exp));
        checkOutput({tag, "_irqB"}, b2w(irqB), b2w(exp));
    endtask

    initial begin
        reset = 1'b1; dlsError = 1'b0; hSel = 1'b0; hAddr = '0; hTrans = 2'b00;
        hWrite = 1'b0; hReady = 1'b1; hWdata = '0;
        modelClearCount();
        repeat (3) tick();
        checkLatch("rst", 1'b0);
        checkIrq("rst", 1'b0);
        checkOutput("rst_readyA", b2w(readyA), 32'd1);
        checkOutput("rst_readyB", b2w(readyB), 32'd1);
        checkOutput("rst_rdataA", rdataA, 32'd0);
        reset = 1'b0;
        tick();
        busRead(5'h08, 32'h2, 32'h2, "ctrl_rst");
        busRead(5'h00, 32'h0, 32'h0, "status_rst");
        busRead(5'h04, 32'h0, 32'h0, "count_rst");

        // Single-cycle glitches never reach the filter threshold.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1);
            applyStimulus(1'b0, 3);
        end
        dlsError = 1'b1;
        busRead(5'h00, st(1, 0, 0, 0), st(1, 0, 0, 0), "status_pend");
        applyStimulus(1'b0, 3);
        checkLatch("glitch", 1'b0);
        checkIrq("glitch", 1'b0);
        busRead(5'h04, 32'h0, 32'h0, "count_glitch");
        busRead(5'h00, 32'h0, 32'h0, "status_glitch");

        busWrite(5'h08, 32'h3);
        dlsError = 1'b1;
        tick();
        checkLatch("confirm_e1", 1'b0);
        tick();
        checkLatch("confirm_e2", 1'b1);
        checkIrq("confirm_e2", 1'b1);
        busRead(5'h00, st(0, 0, 1, 1), st(0, 0, 1, 1), "status_fault");
        applyStimulus(1'b1, 7);
        applyStimulus(1'b0, 2);
        modelConfirm();
        busRead(5'h00, st(0, 0, 0, 1), st(0, 0, 0, 1), "status_after");
        busRead(5'h04, cntA, cntB, "count_one");

        busWrite(5'h0C, 32'h3);
        modelClearCount();
        checkLatch("clr_all", 1'b0);
        checkIrq("clr_all", 1'b0);
        repeat (3) burst();
        busRead(5'h04, cntA, cntB, "count_three");
        busRead(5'h00, st(0, satA, 0, 1), st(0, satB, 0, 1), "status_three");
        busWrite(5'h0C, 32'h1);
        busRead(5'h00, st(0, satA, 0, 0), st(0, satB, 0, 0), "status_clrlatch");
        busRead(5'h04, cntA, cntB, "count_kept");
        checkIrq("clrlatch", 1'b0);
        busWrite(5'h0C, 32'h2);
        modelClearCount();
        busRead(5'h04, 32'h0, 32'h0, "count_cleared");

        repeat (5) burst();
        busRead(5'h04, cntA, cntB, "count_sat");
        busRead(5'h00, st(0, satA, 0, 1), st(0, satB, 0, 1), "status_sat");

        // Clear count on the same edge as a confirm: the confirm lands on a zeroed counter.
        dlsError = 1'b1;
        busWrite(5'h0C, 32'h2);
        modelClearCount();
        modelConfirm();
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 2);
        busRead(5'h04, cntA, cntB, "count_clr_confirm");
        busRead(5'h00, st(0, satA, 0, 1), st(0, satB, 0, 1), "status_clr_confirm");

        dlsError = 1'b1;
        busWrite(5'h0C, 32'h1);
        modelConfirm();
        checkLatch("latch_set_wins", 1'b1);
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 2);
        busRead(5'h04, cntA, cntB, "count_set_wins");

        busWrite(5'h0C, 32'h3);
        modelClearCount();
        busWrite(5'h08, 32'h1);
        applyStimulus(1'b1, 5);
        checkLatch("mon_off", 1'b0);
        busRead(5'h00, 32'h0, 32'h0, "status_mon_off");
        busRead(5'h04, 32'h0, 32'h0, "count_mon_off");
        busWrite(5'h08, 32'h2);
        tick();
        checkLatch("mon_on_e1", 1'b0);
        tick();
        checkLatch("mon_on_e2", 1'b1);
        checkIrq("mon_on_noirq", 1'b0);
        modelConfirm();
        applyStimulus(1'b0, 2);
        busRead(5'h04, cntA, cntB, "count_mon_on");

        // Disabling the monitor on the confirm edge must not lose the event.
        busWrite(5'h0C, 32'h1);
        dlsError = 1'b1;
        busWrite(5'h08, 32'h0);
        modelConfirm();
        checkLatch("mon_off_confirm", 1'b1);
        applyStimulus(1'b1, 3);
        busRead(5'h00, st(0, 0, 0, 1), st(0, 0, 0, 1), "status_mon_off_confirm");
        busRead(5'h04, cntA, cntB, "count_mon_off_confirm");
        dlsError = 1'b0;
        busWrite(5'h08, 32'h3);

        dlsError = 1'b1;
        busRead(5'h00, st(1, 0, 0, 1), st(1, 0, 0, 1), "status_pend_pre_rst");
        reset = 1'b1;
        hSel = 1'b1; hTrans = 2'b10; hWrite = 1'b0; hAddr = 5'h04;
        tick();
        reset = 1'b0;
        hSel = 1'b0; hTrans = 2'b00;
        dlsError = 1'b0;
        modelClearCount();
        checkOutput("rst_mid_rdataA", rdataA, 32'd0);
        checkLatch("rst_mid", 1'b0);
        checkIrq("rst_mid", 1'b0);
        busRead(5'h00, 32'h0, 32'h0, "status_rst_mid");
        busRead(5'h04, 32'h0, 32'h0, "count_rst_mid");
        busRead(5'h08, 32'h2, 32'h2, "ctrl_rst_mid");

        busWrite(5'h14, 32'hFFFF_FFFF);
        busWrite(5'h1C, 32'hFFFF_FFFF);
        busRead(5'h08, 32'h2, 32'h2, "ctrl_after_reserved");
        busRead(5'h18, 32'h0, 32'h0, "reserved_read");
        busRead(5'h0C, 32'h0, 32'h0, "clear_read");

`ifdef DLS_FAULT_TIMESTAMP_EN
        busRead(5'h10, 32'h0, 32'h0, "ts_rst");
        dlsError = 1'b1;
        tick();
        tick();
        tsExp = cyc - 32'd1;
        modelConfirm();
        applyStimulus(1'b0, 2);
        busRead(5'h10, tsExp, tsExp, "ts_first");
        burst();
        busRead(5'h10, tsExp, tsExp, "ts_kept");
        busWrite(5'h0C, 32'h1);
        busRead(5'h10, tsExp, tsExp, "ts_after_clear");
        dlsError = 1'b1;
        tick();
        tick();
        tsExp = cyc - 32'd1;
        modelConfirm();
        applyStimulus(1'b0, 2);
        busRead(5'h10, tsExp, tsExp, "ts_rearmed");
`else
        busRead(5'h10, 32'h0, 32'h0, "ts_absent");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
